// File: rtl/sram_confreg.sv
// sram_confreg: memory-mapped scratch, LED, switch and compare-timer block on the data SRAM-like port.
// Reads have one-cycle synchronous latency; writes apply per byte lane.
module sram_confreg #(
  parameter logic [15:0] BASE_HI = 16'hBFAF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [7:0]  switch,
  output logic [15:0] led,
  output logic        timer_int
);

  localparam logic [2:0] IDX_SCRATCH0 = 3'd0;
  localparam logic [2:0] IDX_SCRATCH1 = 3'd1;
  localparam logic [2:0] IDX_LED      = 3'd2;
  localparam logic [2:0] IDX_SWITCH   = 3'd3;
  localparam logic [2:0] IDX_TIMER    = 3'd4;
  localparam logic [2:0] IDX_COMPARE  = 3'd5;
  localparam logic [2:0] IDX_STATUS   = 3'd6;
  localparam logic [2:0] IDX_CTRL     = 3'd7;

  logic [31:0] scratch0_r;
  logic [31:0] scratch1_r;
  logic [15:0] led_r;
  logic [7:0]  swMeta_r;
  logic [7:0]  swSync_r;
  logic [31:0] timer_r;
  logic [31:0] compare_r;
  logic        pending_r;
  logic        ie_r;
  logic        cmpEn_r;
  logic [31:0] rdata_r;

  logic        hit_s;
  logic        mapped_s;
  logic        wrEn_s;
  logic [2:0]  regIdx_s;
  logic [7:0]  wrSel_s;
  logic [31:0] rdNext_s;
  logic [31:0] timerInc_s;
  logic [31:0] timerNext_s;
  logic        match_s;
  logic        w1c_s;
  logic        pendingNext_s;
  logic [15:0] ledNext_s;
  logic        unusedAddr_s;

  function automatic logic [31:0] byteMerge(
    input logic [31:0] oldVal,
    input logic [31:0] newVal,
    input logic [3:0]  byteEn
  );
    logic [31:0] res;
    res = oldVal;
    for (int i = 0; i < 4; i++) begin
      if (byteEn[i]) begin
        res[i*8 +: 8] = newVal[i*8 +: 8];
      end else begin
        res[i*8 +: 8] = oldVal[i*8 +: 8];
      end
    end
    return res;
  endfunction

  // Address decode: the whole window is 64 KB but only the first eight words are populated.
  always_comb begin
    hit_s    = data_sram_en && (data_sram_addr[31:16] == BASE_HI);
    mapped_s = hit_s && (data_sram_addr[15:5] == 11'd0);
    regIdx_s = data_sram_addr[4:2];
    wrEn_s   = mapped_s && (data_sram_wen != 4'h0);
    if (wrEn_s) begin
      wrSel_s = 8'h01 << regIdx_s;
    end else begin
      wrSel_s = 8'h00;
    end
  end

  assign unusedAddr_s = &{1'b0, data_sram_addr[1:0]};

  // Read mux sees register values before this cycle's updates (read-before-write).
  always_comb begin
    rdNext_s = 32'h0000_0000;
    if (mapped_s) begin
      case (regIdx_s)
        IDX_SCRATCH0: rdNext_s = scratch0_r;
        IDX_SCRATCH1: rdNext_s = scratch1_r;
        IDX_LED:      rdNext_s = {16'h0000, led_r};
        IDX_SWITCH:   rdNext_s = {24'h00_0000, swSync_r};
        IDX_TIMER:    rdNext_s = timer_r;
        IDX_COMPARE:  rdNext_s = compare_r;
        IDX_STATUS:   rdNext_s = {31'h0000_0000, pending_r};
        IDX_CTRL:     rdNext_s = {30'h0000_0000, cmpEn_r, ie_r};
        default:      rdNext_s = 32'h0000_0000;
      endcase
    end else begin
      rdNext_s = 32'h0000_0000;
    end
  end

  // Timer and interrupt next-state; a compare match beats a same-cycle W1C clear.
  always_comb begin
    timerInc_s = timer_r + 32'd1;
    if (wrSel_s[IDX_TIMER]) begin
      timerNext_s = byteMerge(timerInc_s, data_sram_wdata, data_sram_wen);
    end else begin
      timerNext_s = timerInc_s;
    end
    match_s = cmpEn_r && (timer_r == compare_r);
    w1c_s   = wrSel_s[IDX_STATUS] && data_sram_wen[0] && data_sram_wdata[0];
    if (match_s) begin
      pendingNext_s = 1'b1;
    end else if (w1c_s) begin
      pendingNext_s = 1'b0;
    end else begin
      pendingNext_s = pending_r;
    end
    ledNext_s[7:0]  = data_sram_wen[0] ? data_sram_wdata[7:0]  : led_r[7:0];
    ledNext_s[15:8] = data_sram_wen[1] ? data_sram_wdata[15:8] : led_r[15:8];
  end

  // Software-visible storage registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      scratch0_r <= 32'h0000_0000;
      scratch1_r <= 32'h0000_0000;
      led_r      <= 16'h0000;
      compare_r  <= 32'hFFFF_FFFF;
      ie_r       <= 1'b0;
      cmpEn_r    <= 1'b0;
    end else begin
      if (wrSel_s[IDX_SCRATCH0]) begin
        scratch0_r <= byteMerge(scratch0_r, data_sram_wdata, data_sram_wen);
      end
      if (wrSel_s[IDX_SCRATCH1]) begin
        scratch1_r <= byteMerge(scratch1_r, data_sram_wdata, data_sram_wen);
      end
      if (wrSel_s[IDX_LED]) begin
        led_r <= ledNext_s;
      end
      if (wrSel_s[IDX_COMPARE]) begin
        compare_r <= byteMerge(compare_r, data_sram_wdata, data_sram_wen);
      end
      if (wrSel_s[IDX_CTRL] && data_sram_wen[0]) begin
        ie_r    <= data_sram_wdata[0];
        cmpEn_r <= data_sram_wdata[1];
      end
    end
  end

  // Free-running timer and sticky pending flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      timer_r   <= 32'h0000_0000;
      pending_r <= 1'b0;
    end else begin
      timer_r   <= timerNext_s;
      pending_r <= pendingNext_s;
    end
  end

  // Two-flop synchronizer for the asynchronous board switches.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      swMeta_r <= 8'h00;
      swSync_r <= 8'h00;
    end else begin
      swMeta_r <= switch;
      swSync_r <= swMeta_r;
    end
  end

  // Read data register: any access (hit or miss) updates it, idle cycles hold it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_r <= 32'h0000_0000;
    end else if (data_sram_en) begin
      rdata_r <= rdNext_s;
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign data_sram_rdata = rdata_r;
  assign led             = led_r;
  assign timer_int       = pending_r & ie_r;

endmodule

// File: tb/tb_sram_confreg.sv
// Directed bench for sram_confreg: each step drives one access across one clock edge,
// then checks outputs 1 time unit after that edge against hand-computed values.
module tb_sram_confreg;

  localparam logic [15:0] BASE = 16'hBFAF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        en = 1'b0;
  logic [3:0]  wen = 4'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic [31:0] rdata;
  logic [7:0]  sw = 8'h81;
  logic [15:0] led;
  logic        tint;

  int passCnt = 0;
  int failCnt = 0;
  int totalCnt = 0;

  always #5 clk = ~clk;

  sram_confreg #(.BASE_HI(16'hBFAF)) dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (en),
    .data_sram_wen   (wen),
    .data_sram_addr  (addr),
    .data_sram_wdata (wdata),
    .data_sram_rdata (rdata),
    .switch          (sw),
    .led             (led),
    .timer_int       (tint)
  );

  function automatic logic [31:0] ra(input logic [7:0] off);
    return {BASE, 8'h00, off};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCnt++;
    assert (obs === exp) begin
      passCnt++;
    end else begin
      failCnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    en = e; wen = w; addr = a; wdata = d;
    @(posedge clk); #1;
    en = 1'b0; wen = 4'h0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;

    // timer starts at 0 on the first edge after reset release
    step(1'b1, 4'h0, ra(8'h10), 32'h0);
    check("timer_after_reset", rdata, 32'h0000_0000);

    // LED write: upper bits dropped, pin follows after the edge
    step(1'b1, 4'hF, ra(8'h08), 32'hFFFF_A5A5);
    check("led_prewrite_rdata", rdata, 32'h0000_0000);
    check("led_pin", {16'h0000, led}, 32'h0000_A5A5);
    step(1'b1, 4'h0, ra(8'h08), 32'h0);
    check("led_readback", rdata, 32'h0000_A5A5);

    // reset in the middle of a SCRATCH0 write
    step(1'b1, 4'hF, ra(8'h00), 32'h1234_5678);
    step(1'b1, 4'h0, ra(8'h00), 32'h0);
    check("scratch0_before_rst", rdata, 32'h1234_5678);
    en = 1'b1; wen = 4'hF; addr = ra(8'h00); wdata = 32'h1234_5678;
    #2 resetn = 1'b0;
    #1;
    check("rst_rdata", rdata, 32'h0000_0000);
    check("rst_led", {16'h0000, led}, 32'h0000_0000);
    check("rst_int", {31'h0, tint}, 32'h0000_0000);
    @(posedge clk); #1;
    en = 1'b0; wen = 4'h0; resetn = 1'b1;
    step(1'b1, 4'h0, ra(8'h00), 32'h0);
    check("scratch0_after_rst", rdata, 32'h0000_0000);
    step(1'b1, 4'h0, ra(8'h14), 32'h0);
    check("compare_after_rst", rdata, 32'hFFFF_FFFF);
    check("led_after_rst", {16'h0000, led}, 32'h0000_0000);

    // byte-lane write
    step(1'b1, 4'hF, ra(8'h04), 32'hAABB_CCDD);
    step(1'b1, 4'h2, ra(8'h04), 32'h0000_1100);
    step(1'b1, 4'h0, ra(8'h04), 32'h0);
    check("scratch1_bytewrite", rdata, 32'hAABB_11DD);

    // read-during-write returns old value
    step(1'b1, 4'hF, ra(8'h00), 32'h0000_0003);
    step(1'b1, 4'hF, ra(8'h00), 32'h0000_0005);
    check("rdw_old", rdata, 32'h0000_0003);
    step(1'b1, 4'h0, ra(8'h00), 32'h0);
    check("rdw_new", rdata, 32'h0000_0005);
    step(1'b0, 4'h0, ra(8'h04), 32'h0);
    check("idle_hold", rdata, 32'h0000_0005);

    // misses and unmapped offsets
    step(1'b1, 4'h0, 32'h1234_0000, 32'h0);
    check("miss_read", rdata, 32'h0000_0000);
    step(1'b1, 4'hF, 32'h1234_0000, 32'hDEAD_BEEF);
    step(1'b1, 4'hF, ra(8'h20), 32'hFFFF_FFFF);
    step(1'b1, 4'h0, ra(8'h00), 32'h0);
    check("miss_no_write", rdata, 32'h0000_0005);
    step(1'b1, 4'h0, ra(8'h20), 32'h0);
    check("unmapped_read", rdata, 32'h0000_0000);

    // timer compare and interrupt
    step(1'b1, 4'hF, ra(8'h10), 32'h0000_0010);
    step(1'b1, 4'hF, ra(8'h14), 32'h0000_0014);
    step(1'b1, 4'hF, ra(8'h1C), 32'h0000_0003);
    step(1'b1, 4'h0, ra(8'h10), 32'h0);
    check("timer_12", rdata, 32'h0000_0012);
    step(1'b1, 4'h0, ra(8'h10), 32'h0);
    check("timer_13", rdata, 32'h0000_0013);
    check("int_low_before", {31'h0, tint}, 32'h0000_0000);
    step(1'b1, 4'h0, ra(8'h10), 32'h0);
    check("timer_14", rdata, 32'h0000_0014);
    check("int_rise", {31'h0, tint}, 32'h0000_0001);
    step(1'b1, 4'hF, ra(8'h18), 32'h0000_0001);
    check("status_prewrite", rdata, 32'h0000_0001);
    check("int_w1c_clear", {31'h0, tint}, 32'h0000_0000);
    step(1'b1, 4'hF, ra(8'h14), 32'h0000_001A);
    step(1'b0, 4'h0, ra(8'h00), 32'h0);
    step(1'b0, 4'h0, ra(8'h00), 32'h0);
    step(1'b0, 4'h0, ra(8'h00), 32'h0);
    check("int_low_pre_match", {31'h0, tint}, 32'h0000_0000);
    step(1'b1, 4'hF, ra(8'h18), 32'h0000_0001);
    check("int_set_wins", {31'h0, tint}, 32'h0000_0001);
    step(1'b1, 4'h0, ra(8'h18), 32'h0);
    check("status_set_wins", rdata, 32'h0000_0001);
    step(1'b1, 4'hF, ra(8'h18), 32'h0000_0001);
    check("int_second_clear", {31'h0, tint}, 32'h0000_0000);
    step(1'b1, 4'h0, ra(8'h1C), 32'h0);
    check("ctrl_readback", rdata, 32'h0000_0003);

    // wrap and partial timer write
    step(1'b1, 4'hF, ra(8'h10), 32'hFFFF_FFFE);
    step(1'b1, 4'h0, ra(8'h10), 32'h0);
    check("wrap_fe", rdata, 32'hFFFF_FFFE);
    step(1'b1, 4'h0, ra(8'h10), 32'h0);
    check("wrap_ff", rdata, 32'hFFFF_FFFF);
    step(1'b1, 4'h0, ra(8'h10), 32'h0);
    check("wrap_zero", rdata, 32'h0000_0000);
    step(1'b1, 4'h2, ra(8'h10), 32'h0000_3300);
    step(1'b1, 4'h0, ra(8'h10), 32'h0);
    check("timer_bytewrite", rdata, 32'h0000_3302);

    // switch synchronizer latency
    sw = 8'h5A;
    step(1'b0, 4'h0, ra(8'h00), 32'h0);
    step(1'b1, 4'h0, ra(8'h0C), 32'h0);
    check("switch_old", rdata, 32'h0000_0081);
    step(1'b1, 4'h0, ra(8'h0C), 32'h0);
    check("switch_new", rdata, 32'h0000_005A);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/sram_confreg.md
# sram_confreg

Memory-mapped configuration/peripheral responder on the CPU data SRAM-like port. Decodes one 64 KB window and serves scratch registers, LEDs, synchronized switches and a 32-bit timer with compare interrupt. It has synchronous-SRAM read behaviour, so it can sit beside the data RAM behind the same address decode. The timer interrupt output feeds one bit of the CPU `int[15:0]` vector.

## Interface
- `BASE_HI`, default 16'hBFAF, upper address half (`addr[31:16]`) that selects this block.
- `clk` in 1: single clock; all state updates on rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `data_sram_en` in 1: access strobe.
- `data_sram_wen` in 4: byte write enables; 0 = read.
- `data_sram_addr` in 32: byte address; `[1:0]` ignored.
- `data_sram_wdata` in 32: write data.
- `data_sram_rdata` out 32: read data, registered.
- `switch` in 8: asynchronous board switches.
- `led` out 16: LED register.
- `timer_int` out 1: level interrupt, equals `pending & ie`.

## Operation
- Hit = `data_sram_en && addr[31:16]==BASE_HI`. Offset = `addr[15:0]`.
- Register map; each write applies per-byte using `wen`:
  - 0x00 SCRATCH0: RW 32.
  - 0x04 SCRATCH1: RW 32.
  - 0x08 LED: RW, `[15:0]`, reads upper bits 0.
  - 0x0C SWITCH: RO, two-flop synchronized `switch`, upper bits 0.
  - 0x10 TIMER: RW, free-running +1 per cycle, wraps 0xFFFFFFFF→0.
  - 0x14 COMPARE: RW 32.
  - 0x18 STATUS: bit0 `pending`. Write 1 to bit0 clears it (W1C); other bits read 0.
  - 0x1C CTRL: bit0 `ie`, bit1 `cmp_en`, RW.
- Unmapped offset in window, or miss: the read returns 0 and the write is ignored.
- TIMER write: the written bytes load `wdata`, and unwritten bytes take `timer+1`. The write replaces the increment for that cycle.
- Match: `cmp_en && timer==COMPARE`, evaluated on the current (pre-update) timer value. A match sets `pending` on the next edge.
- Set and W1C clear in the same cycle: set wins, and `pending` stays 1.
- A compare match does not stop or reload the timer.

## Timing
- Read latency 1: `rdata` is updated at the edge where `en` is sampled. It is valid the whole following cycle and held until the next hit or miss access.
- A cycle with `en=0` leaves `rdata` unchanged.
- Access with `wen!=0`: `rdata` returns the pre-write register value. The new value is visible on a read issued the next cycle.
- TIMER read returns its value at the sampling edge, before that cycle's increment.
- SWITCH: a pin change is visible in the register 2 edges later. A read issued in the 3rd cycle after the change returns it.
- `timer_int` is combinational from the `pending`/`ie` flops, so it rises 1 cycle after the match cycle.
- Reset (async, any time, mid-access included) values:
  - All SCRATCH registers, LED, TIMER, STATUS, CTRL, sync flops and `rdata` = 0.
  - COMPARE = 0xFFFFFFFF.
  - `led` = 0, `timer_int` = 0.
- After `resetn` rises, TIMER counts from 0 starting on the first edge.
- There is no back-pressure, and every access completes in one cycle.

## Test plan
- Reset mid-write to SCRATCH0 (`wen`=0xF, 0x12345678): after reset, a read of 0x00 returns 0, COMPARE reads 0xFFFFFFFF, and `led`=0.
- Byte writes:
  - Write SCRATCH1=0xAABBCCDD, then `wen`=0x2 with `wdata`=0x00001100; the next read returns 0xAABB11DD.
  - Write LED 0x0000A5A5; `led`=0xA5A5 the cycle after the write.
- Read-during-write: same-cycle write 0x5 to SCRATCH0 (old value 0x3) returns 0x3. The next read returns 0x5.
- Timer compare:
  - Write TIMER=0x10 and COMPARE=0x14, then CTRL=0x3. `timer_int` rises one cycle after TIMER reads 0x14.
  - Write STATUS=1 on a non-match cycle: `pending` clears and `timer_int` falls the next cycle.
  - W1C on the match cycle: `pending` stays 1.
- Wrap and miss:
  - TIMER loaded with 0xFFFFFFFE reads 0xFFFFFFFF, then 0 on consecutive reads.
  - An access with `addr[31:16]`≠BASE_HI returns 0 and changes no register.
  - Offset 0x20 reads 0.
- Switch sync: `switch` changes to 0x5A. A read issued 3 cycles later returns 0x5A, and a read issued 1 cycle later returns the old value.
